// File: rtl/machine_timer_pkg.sv
// Shared definitions for the machine timer: register map, CTRL bit indices
// and the interrupt pin index used by the top-level wiring.
package machine_timer_pkg;

    localparam logic [4:0] TIMER_MTIME_LO = 5'h00;
    localparam logic [4:0] TIMER_MTIME_HI = 5'h04;
    localparam logic [4:0] TIMER_CMP_LO   = 5'h08;
    localparam logic [4:0] TIMER_CMP_HI   = 5'h0C;
    localparam logic [4:0] TIMER_CTRL     = 5'h10;
    localparam logic [4:0] TIMER_PRESCALE = 5'h14;

    localparam int unsigned TIMER_CTRL_EN = 0;
    localparam int unsigned TIMER_CTRL_IE = 1;

    localparam int unsigned CLOCK_IRQ_PIN = 7;

    typedef enum logic [2:0] {
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_CTRL,
        REG_PRESCALE,
        REG_NONE
    } timer_reg_e;

    // Full 5-bit match, so misaligned offsets fall through to REG_NONE.
    function automatic timer_reg_e decode_reg(input logic [4:0] addr);
        case (addr)
            TIMER_MTIME_LO: return REG_MTIME_LO;
            TIMER_MTIME_HI: return REG_MTIME_HI;
            TIMER_CMP_LO:   return REG_CMP_LO;
            TIMER_CMP_HI:   return REG_CMP_HI;
            TIMER_CTRL:     return REG_CTRL;
            TIMER_PRESCALE: return REG_PRESCALE;
            default:        return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/machine_timer_prescaler.sv
// Programmable divider: emits a one-cycle tick every (prescale + 1) enabled
// cycles; the clear input restarts the count.
module timer_prescaler #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count;

    always_comb begin
        tick = en && (count == prescale);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped 64-bit machine timer with prescaler, atomic 64-bit access
// helpers (read snapshot, write shadow) and a level interrupt.
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16,
    parameter logic [63:0] RESET_CMP  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic        bus_ack,
    output logic [31:0] bus_rdata,
    output logic        timer_irq
);

    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic [31:0]           cmp_lo_shadow;
    logic [31:0]           mtime_hi_snap;
    logic                  ctrl_en;
    logic                  ctrl_ie;
    logic [PRESCALE_W-1:0] prescale;
    logic                  tick;

    timer_reg_e  sel;
    logic        wr;
    logic        rd;
    logic [31:0] rdata_next;

    always_comb begin
        sel = bus_req ? decode_reg(bus_addr) : REG_NONE;
        wr  = bus_req && bus_we;
        rd  = bus_req && !bus_we;
    end

    always_comb begin
        rdata_next = '0;
        if (rd) begin
            case (sel)
                REG_MTIME_LO: rdata_next = mtime[31:0];
                REG_MTIME_HI: rdata_next = mtime_hi_snap;
                REG_CMP_LO:   rdata_next = mtimecmp[31:0];
                REG_CMP_HI:   rdata_next = mtimecmp[63:32];
                REG_CTRL:     rdata_next = {30'b0, ctrl_ie, ctrl_en};
                REG_PRESCALE: rdata_next = 32'(prescale);
                default:      rdata_next = '0;
            endcase
        end
    end

    timer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (ctrl_en),
        .clear    (wr && (sel == REG_PRESCALE)),
        .prescale (prescale),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            timer_irq <= 1'b0;
        end else begin
            bus_ack   <= bus_req;
            bus_rdata <= rdata_next;
            timer_irq <= ctrl_ie && (mtime >= mtimecmp);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mtimecmp      <= RESET_CMP;
            cmp_lo_shadow <= '0;
            mtime_hi_snap <= '0;
            ctrl_en       <= 1'b0;
            ctrl_ie       <= 1'b0;
            prescale      <= '0;
        end else begin
            if (rd && (sel == REG_MTIME_LO)) begin
                mtime_hi_snap <= mtime[63:32];
            end
            if (wr) begin
                case (sel)
                    REG_CMP_LO:   cmp_lo_shadow <= bus_wdata;
                    REG_CMP_HI:   mtimecmp      <= {bus_wdata, cmp_lo_shadow};
                    REG_CTRL: begin
                        ctrl_en <= bus_wdata[TIMER_CTRL_EN];
                        ctrl_ie <= bus_wdata[TIMER_CTRL_IE];
                    end
                    REG_PRESCALE: prescale <= bus_wdata[PRESCALE_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // A software write to either half takes priority and swallows a coincident tick.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mtime <= '0;
        end else if (wr && (sel == REG_MTIME_LO)) begin
            mtime[31:0] <= bus_wdata;
        end else if (wr && (sel == REG_MTIME_HI)) begin
            mtime[63:32] <= bus_wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: bus responses are checked against a
// scoreboard queue, interrupt timing against hand-derived cycle counts.
module tb_machine_timer;
    import machine_timer_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        bus_req;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        timer_irq;

    always #5 clk = ~clk;

    machine_timer #(
        .PRESCALE_W (16),
        .RESET_CMP  (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .timer_irq (timer_irq)
    );

    typedef struct {
        string       tag;
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        sb.push_back('{tag: tag, lo: 32'h0, hi: 32'h0});
        cyc();
        bus_req = 1'b0;
        bus_we  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] lo, input logic [31:0] hi);
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = a;
        sb.push_back('{tag: tag, lo: lo, hi: hi});
        cyc();
        bus_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (clr_n === 1'b1) begin
            if (bus_ack === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $error("FAIL spurious_ack: observed ack with no request outstanding, required none");
                end else begin
                    e = sb.pop_front();
                    assert (!$isunknown(bus_rdata) && bus_rdata >= e.lo && bus_rdata <= e.hi) else begin
                        miscompares++;
                        $error("FAIL %s: observed %0h expected %0h..%0h", e.tag, bus_rdata, e.lo, e.hi);
                    end
                end
            end else begin
                check("idle_rdata", {32'h0, bus_rdata}, 64'h0);
            end
        end
    end

    initial begin
        clr_n     = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        repeat (3) @(posedge clk);
        #1 clr_n = 1'b1;

        // Reset state
        check("irq_reset", timer_irq, 1'b0);
        check("ack_reset", bus_ack, 1'b0);
        rd("ctrl_reset",     TIMER_CTRL,     32'h0, 32'h0);
        rd("cmp_lo_reset",   TIMER_CMP_LO,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd("cmp_hi_reset",   TIMER_CMP_HI,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd("prescale_reset", TIMER_PRESCALE, 32'h0, 32'h0);
        rd("mtime_reset",    TIMER_MTIME_LO, 32'h0, 32'h0);

        // Prescale 3: one tick every 4 enabled cycles
        wr("w_prescale3", TIMER_PRESCALE, 32'd3);
        wr("w_ctrl_en",   TIMER_CTRL,     32'd1);
        repeat (40) cyc();
        rd("mtime_prescaled", TIMER_MTIME_LO, 32'd9, 32'd11);
        wr("w_ctrl_off", TIMER_CTRL, 32'd0);
        rd("mtime_frozen_a", TIMER_MTIME_LO, 32'd10, 32'd10);
        rd("mtime_frozen_b", TIMER_MTIME_LO, 32'd10, 32'd10);
        rd("prescale_rd",    TIMER_PRESCALE, 32'd3, 32'd3);

        // Snapshot across the low-to-high carry
        wr("w_prescale0", TIMER_PRESCALE, 32'd0);
        wr("w_mtime_hi0", TIMER_MTIME_HI, 32'd0);
        wr("w_mtime_lo",  TIMER_MTIME_LO, 32'hFFFF_FFFE);
        wr("w_ctrl_en2",  TIMER_CTRL,     32'd1);
        cyc();
        rd("snap_lo_pre",  TIMER_MTIME_LO, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd("snap_hi_pre",  TIMER_MTIME_HI, 32'd0, 32'd0);
        rd("snap_lo_post", TIMER_MTIME_LO, 32'd1, 32'd1);
        rd("snap_hi_post", TIMER_MTIME_HI, 32'd1, 32'd1);

        // Compare and interrupt
        wr("w_ctrl_off2", TIMER_CTRL,     32'd0);
        wr("w_mtime_hi",  TIMER_MTIME_HI, 32'd0);
        wr("w_mtime_lo0", TIMER_MTIME_LO, 32'd0);
        wr("w_cmp_lo",    TIMER_CMP_LO,   32'd100);
        rd("cmp_lo_shadowed", TIMER_CMP_LO, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("irq_after_cmp_lo", timer_irq, 1'b0);
        wr("w_cmp_hi0", TIMER_CMP_HI, 32'd0);
        rd("cmp_lo_committed", TIMER_CMP_LO, 32'd100, 32'd100);
        rd("cmp_hi_committed", TIMER_CMP_HI, 32'd0, 32'd0);
        wr("w_ctrl_3", TIMER_CTRL, 32'd3);
        for (int i = 1; i <= 101; i++) begin
            cyc();
            if (i == 100) check("irq_before_match", timer_irq, 1'b0);
            if (i == 101) check("irq_after_match",  timer_irq, 1'b1);
        end

        // Clearing via compare commit, then via IE
        wr("w_cmp_hi1", TIMER_CMP_HI, 32'd1);
        check("irq_commit_edge", timer_irq, 1'b1);
        cyc();
        check("irq_cleared_cmp", timer_irq, 1'b0);
        wr("w_cmp_lo5", TIMER_CMP_LO, 32'd5);
        wr("w_cmp_hi0b", TIMER_CMP_HI, 32'd0);
        cyc();
        check("irq_reassert", timer_irq, 1'b1);
        wr("w_ctrl_ie_off", TIMER_CTRL, 32'd1);
        check("irq_ie_edge", timer_irq, 1'b1);
        cyc();
        check("irq_cleared_ie", timer_irq, 1'b0);

        // Write collides with a tick; unmapped and misaligned offsets
        wr("w_collide", TIMER_MTIME_LO, 32'd5);
        rd("collide_write_wins", TIMER_MTIME_LO, 32'd5, 32'd5);
        rd("unmapped_rd",   5'h18, 32'h0, 32'h0);
        rd("misaligned_rd", 5'h01, 32'h0, 32'h0);
        wr("unmapped_wr",   5'h18, 32'hFFFF_FFFF);
        wr("misaligned_wr", 5'h11, 32'h0);
        rd("ctrl_untouched", TIMER_CTRL, 32'd1, 32'd1);

        // Reset while an ack is pending
        cyc();
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = TIMER_CTRL;
        cyc();
        bus_req = 1'b0;
        check("ack_pending", bus_ack, 1'b1);
        #1 clr_n = 1'b0;
        #1;
        check("ack_dropped_by_reset", bus_ack, 1'b0);
        check("rdata_dropped_by_reset", {32'h0, bus_rdata}, 64'h0);
        check("irq_dropped_by_reset", timer_irq, 1'b0);
        cyc();
        cyc();
        clr_n = 1'b1;
        rd("cmp_hi_after_reset", TIMER_CMP_HI, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd("mtime_after_reset",  TIMER_MTIME_LO, 32'h0, 32'h0);
        cyc();
        cyc();
        check("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/machine_timer.md
Name: machine_timer

Overview:
- Memory-mapped machine timer that produces the clock interrupt consumed by the interrupt manager on `irq_pins[CLOCK_IRQ_PIN]`.
- Holds a 64-bit mtime counter, advanced by a programmable prescaler, and a 64-bit mtimecmp compare register.
- Asserts a level interrupt while mtime >= mtimecmp and the interrupt is enabled.
- Sits on the data-memory side of MEM; software reprograms mtimecmp in the trap handler to clear the request.

Parameters:
- PRESCALE_W, 16, width of the prescaler divide register.
- RESET_CMP, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp, chosen so no interrupt fires out of reset.

Ports:
- clk  in  1  system clock.
- clr_n  in  1  reset, asynchronous, active-low.
- bus_req  in  1  single-cycle access request.
- bus_we  in  1  1 = write, 0 = read; sampled with bus_req.
- bus_addr  in  5  byte offset: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 CMP_LO, 0x0C CMP_HI, 0x10 CTRL, 0x14 PRESCALE.
- bus_wdata  in  32  write data.
- bus_ack  out  1  response strobe, exactly one cycle after bus_req.
- bus_rdata  out  32  read data, valid while bus_ack = 1, otherwise 0.
- timer_irq  out  1  level interrupt to `irq_pins[CLOCK_IRQ_PIN]`.

Behaviour:
- Reset (async assert, sync release):
  - mtime = 0, mtimecmp = RESET_CMP, cmp_lo_shadow = 0, mtime_hi_snap = 0.
  - CTRL = 0, PRESCALE = 0, prescaler count = 0.
  - bus_ack = 0, bus_rdata = 0, timer_irq = 0.
  - Reset mid-access drops any pending ack.
- CTRL fields: bit0 EN (counter runs), bit1 IE (interrupt enable). Bits 31:2 read 0 and ignore writes.
- Prescaler:
  - While EN = 1, the count increments every clk.
  - When count == PRESCALE: count wraps to 0 and tick = 1 for one cycle.
  - PRESCALE = 0 gives a tick every cycle.
  - EN = 0 freezes both the count and mtime.
  - Writing PRESCALE clears the count.
- mtime:
  - Increments by 1 on tick; modulo 2^64, so FFFF_FFFF_FFFF_FFFF wraps to 0.
  - Carry from the low to the high word happens in the same cycle as the increment.
- Bus protocol:
  - bus_req may be asserted every cycle; responses are pipelined with fixed 1-cycle latency.
  - bus_ack is a registered copy of bus_req.
  - Unmapped offsets and bus_addr[1:0] != 0 still ack: reads return 0, writes are ignored.
- Atomic 64-bit access:
  - Read MTIME_LO returns mtime[31:0] and in the same cycle latches mtime[63:32] into mtime_hi_snap.
  - Read MTIME_HI returns mtime_hi_snap, not the live value.
  - Write CMP_LO updates only cmp_lo_shadow; mtimecmp is unchanged.
  - Write CMP_HI commits {bus_wdata, cmp_lo_shadow} to mtimecmp in one cycle.
  - Read CMP_LO / CMP_HI return the committed mtimecmp halves.
  - Write MTIME_LO / MTIME_HI replaces that half of mtime directly.
- Simultaneous events:
  - A software write to mtime in the same cycle as a tick: the write wins and that tick is lost.
  - A CMP_HI commit in the same cycle as a tick: the compare next cycle uses the new mtimecmp against the incremented mtime.
- Interrupt:
  - timer_irq is registered: timer_irq <= IE & (mtime >= mtimecmp), unsigned 64-bit compare on current register values.
  - Effective latency is one cycle after the condition becomes true.
  - Deasserts one cycle after a CMP_HI commit moves mtimecmp above mtime, or one cycle after IE is cleared.
  - No internal pending latch: the level is the only state.

Decomposition:
- define.v gains:
  - the timer register offsets: `TIMER_MTIME_LO`, `TIMER_MTIME_HI`, `TIMER_CMP_LO`, `TIMER_CMP_HI`, `TIMER_CTRL`, `TIMER_PRESCALE`;
  - the CTRL bit indices: `TIMER_CTRL_EN`, `TIMER_CTRL_IE`;
  - the existing `CLOCK_IRQ_PIN` index, reused by the top level for wiring.
- One sub-module: timer_prescaler (count register, compare, tick output, clear input), parameterised by PRESCALE_W.
- Register file, snapshot/shadow logic and compare stay in machine_timer.

Test Plan:
- Reset: hold clr_n = 0 for 3 cycles, release -> timer_irq = 0; read CTRL = 0; read CMP_LO = FFFF_FFFF, CMP_HI = FFFF_FFFF.
- Prescale: PRESCALE = 3, CTRL = 1; wait 40 cycles; read MTIME_LO -> 10 (±1 for bus latency); with EN = 0 two consecutive reads are equal.
- Snapshot/wrap: PRESCALE = 0, write MTIME_HI = 0, MTIME_LO = FFFF_FFFE, CTRL = 1; then read MTIME_LO and MTIME_HI back-to-back -> HI value equals the value at the LO read; a subsequent LO/HI pair shows HI = 1 after the carry.
- Compare/irq: mtime running from 0, PRESCALE = 0; write CMP_LO = 100 (irq stays 0), CMP_HI = 0, CTRL = 3 -> timer_irq rises exactly one cycle after mtime reaches 100.
- Clear: write CMP_HI = 1 -> irq drops the next cycle. Clearing IE with the condition still true -> irq drops the next cycle.
- Collisions and unmapped access:
  - Write MTIME_LO = 5 in the same cycle as a tick -> reads 5, not 6.
  - Read offset 0x18 -> ack with rdata 0.
  - Reset asserted during a pending ack -> bus_ack = 0 immediately.
